// File: rtl/mac_pkg.sv
// Shared widths, accumulator limits and sequencer state encoding for the MAC datapath.
// Requantisation (MAC_SEQ_REQUANT_EN) reuses DATA_W/ACC_W from here.
package mac_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;

    localparam logic signed [ACC_W-1:0] ACC_MAX = 20'sh7FFFF;
    localparam logic signed [ACC_W-1:0] ACC_MIN = 20'sh80000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } state_t;

    // The PE saturates, so a pinned accumulator means the true sum overflowed.
    function automatic logic is_sat(input logic signed [ACC_W-1:0] v);
        return (v == ACC_MAX) || (v == ACC_MIN);
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Operand and result streams of the MAC sequencer; slave is the sequencer side.
// res_q8 exists only when MAC_SEQ_REQUANT_EN is defined.
interface mac_sequencer_if;
    import mac_pkg::*;

    logic                     op_valid;
    logic                     op_ready;
    logic signed [DATA_W-1:0] op_weight;
    logic signed [DATA_W-1:0] op_input;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [ACC_W-1:0]  res_data;
    logic                     res_sat;
`ifdef MAC_SEQ_REQUANT_EN
    logic signed [DATA_W-1:0] res_q8;
`endif

    modport slave (
        input  op_valid, op_weight, op_input, res_ready,
        output op_ready, res_valid, res_data, res_sat
`ifdef MAC_SEQ_REQUANT_EN
        , output res_q8
`endif
    );

    modport master (
        output op_valid, op_weight, op_input, res_ready,
        input  op_ready, res_valid, res_data, res_sat
`ifdef MAC_SEQ_REQUANT_EN
        , input res_q8
`endif
    );

endinterface

// File: rtl/mac_requant.sv
// Round-half-up arithmetic shift of the accumulator, saturated to int8.
// Purely combinational; only instantiated under MAC_SEQ_REQUANT_EN.
module mac_requant
    import mac_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc,
    input  logic        [3:0]        shift,
    output logic signed [DATA_W-1:0] q8
);

    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(-128);

    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shr;

    always_comb begin
        rnd = '0;
        if (shift != 4'd0)
            rnd = (ACC_W+1)'(1) << (shift - 4'd1);
        // One guard bit keeps ACC_MAX plus the rounding term from wrapping.
        sum = {acc[ACC_W-1], acc} + rnd;
        shr = sum >>> shift;
        if (shr > Q_MAX)
            q8 = 8'sd127;
        else if (shr < Q_MIN)
            q8 = -8'sd128;
        else
            q8 = shr[DATA_W-1:0];
    end

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one dot product through an external MAC PE: clear, stream len pairs, drain, report.
// Optional int8 requantised result under MAC_SEQ_REQUANT_EN.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int DRAIN_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [6:0]               len,
    output logic                     busy,
    output logic                     mac_enable,
    output logic                     mac_clear,
    output logic signed [DATA_W-1:0] mac_weight,
    output logic signed [DATA_W-1:0] mac_input,
    input  logic signed [ACC_W-1:0]  mac_acc,
`ifdef MAC_SEQ_REQUANT_EN
    input  logic [3:0]               shift,
`endif
    mac_sequencer_if.slave           bus
);

    state_t     state;
    logic [6:0] remaining;
    logic [2:0] drain_cnt;
    logic       op_hs;

    assign op_hs = bus.op_valid && bus.op_ready;

`ifdef MAC_SEQ_REQUANT_EN
    logic signed [DATA_W-1:0] q8_next;

    mac_requant u_requant (
        .acc   (mac_acc),
        .shift (shift),
        .q8    (q8_next)
    );
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            remaining     <= '0;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            mac_enable    <= 1'b0;
            mac_clear     <= 1'b0;
            mac_weight    <= '0;
            mac_input     <= '0;
            bus.op_ready  <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_sat   <= 1'b0;
`ifdef MAC_SEQ_REQUANT_EN
            bus.res_q8    <= '0;
`endif
        end else begin
            mac_clear  <= 1'b0;
            mac_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && len != 7'd0) begin
                        remaining <= len;
                        busy      <= 1'b1;
                        mac_clear <= 1'b1;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    bus.op_ready <= 1'b1;
                    state        <= S_STREAM;
                end
                S_STREAM: begin
                    if (op_hs) begin
                        mac_enable <= 1'b1;
                        mac_weight <= bus.op_weight;
                        mac_input  <= bus.op_input;
                        remaining  <= remaining - 7'd1;
                        if (remaining == 7'd1) begin
                            bus.op_ready <= 1'b0;
                            drain_cnt    <= 3'(DRAIN_LAT);
                            state        <= S_DRAIN;
                        end
                    end
                end
                // First DRAIN cycle still carries the final mac_enable.
                S_DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        bus.res_data  <= mac_acc;
                        bus.res_sat   <= is_sat(mac_acc);
`ifdef MAC_SEQ_REQUANT_EN
                        bus.res_q8    <= q8_next;
`endif
                        bus.res_valid <= 1'b1;
                        state         <= S_RESULT;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_LAT, default 1: idle cycles after the last mac_enable before mac_acc is captured (range 1..7).
REQ-002 SHALL have port: clock, in, 1, rising-edge system clock.
REQ-003 SHALL have port: reset, in, 1, asynchronous, active-high reset.
REQ-004 SHALL have port: start, in, 1, begin one dot product; sampled only in IDLE.
REQ-005 SHALL have port: len, in, 7, operand-pair count, 1..127; sampled with start.
REQ-006 SHALL have port: busy, out, 1, high whenever state != IDLE.
REQ-007 SHALL have ports: op_valid (in, 1), op_ready (out, 1), op_weight (in, 8 signed), op_input (in, 8 signed), forming the operand stream.
REQ-008 SHALL have ports: mac_enable (out, 1), mac_clear (out, 1), mac_weight (out, 8 signed), mac_input (out, 8 signed), driving the MAC PE.
REQ-009 SHALL have port: mac_acc, in, 20 signed, saturating accumulator from the MAC PE.
REQ-010 SHALL have ports: res_valid (out, 1), res_ready (in, 1), res_data (out, 20 signed), res_sat (out, 1), forming the result stream.

Function
REQ-011 SHALL implement FSM IDLE, CLEAR, STREAM, DRAIN, RESULT, with all outputs registered.
REQ-012 IDLE: on start=1 with len!=0, latch len into the remaining-count register and go to CLEAR; start with len=0 SHALL be ignored.
REQ-013 CLEAR: mac_clear=1 for exactly one cycle, then go to STREAM; mac_clear SHALL be 0 in every other state.
REQ-014 STREAM: op_ready=1; each op_valid&op_ready handshake in cycle c SHALL drive mac_enable=1 with that pair on mac_weight/mac_input in cycle c+1; with no handshake in cycle c, mac_enable=0 in c+1.
REQ-015 STREAM: the count decrements per handshake; the handshake that brings it to 0 SHALL drop op_ready next cycle and enter DRAIN.
REQ-016 DRAIN: wait DRAIN_LAT cycles after the last mac_enable cycle, capture mac_acc into res_data, set res_valid=1, go to RESULT.
REQ-017 With op_valid held high, start in cycle 0 SHALL give mac_clear in cycle 1, mac_enable in cycles 3..len+2, and res_valid first high in cycle len+3+DRAIN_LAT.
REQ-018 res_sat SHALL be 1 when the captured value equals 20'h7FFFF or 20'h80000, otherwise 0.
REQ-019 RESULT: res_valid, res_data and res_sat SHALL hold stable until res_ready=1; the handshake cycle returns to IDLE, with res_valid=0 next cycle.
REQ-020 start asserted outside IDLE SHALL be ignored; op_weight/op_input SHALL be ignored while op_ready=0.
REQ-021 mac_weight/mac_input SHALL hold their last values when mac_enable=0.

Reset
REQ-022 While reset=1, the FSM SHALL be IDLE and every output 0 (busy, op_ready, mac_enable, mac_clear, mac_weight, mac_input, res_valid, res_data, res_sat), including reset asserted mid-transaction.
REQ-023 A transaction interrupted by reset SHALL be abandoned; the next start after release SHALL begin with CLEAR.

Configuration
REQ-024 With MAC_SEQ_REQUANT_EN defined, SHALL add input shift (4) and output res_q8 (8 signed), computed as sat_int8((acc + (shift?1<<(shift-1):0)) >>> shift), registered with res_data, reset to 0.
REQ-025 Without MAC_SEQ_REQUANT_EN, the ports shift and res_q8 and the requant logic SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-026 SHALL take DATA_W=8, ACC_W=20, ACC_MAX/ACC_MIN and the FSM state enum from shared package mac_pkg.
REQ-027 SHALL place requant round/saturate in sub-module mac_requant (combinational), instantiated only under MAC_SEQ_REQUANT_EN.

Verification
REQ-028 Bench SHALL cover: len=1, pair (5,3), res_ready=1, DRAIN_LAT=1 -> one mac_clear cycle, one mac_enable cycle, res_data=15, res_valid first in cycle 5.
REQ-029 Bench SHALL cover: len=2, pairs (5,3),(2,4), op_valid low 2 cycles between them -> exactly 2 mac_enable pulses, res_data=23, res_sat=0.
REQ-030 Bench SHALL cover: len=50 of (127,127) -> res_data=20'h7FFFF, res_sat=1; then len=50 of (-128,127) -> 20'h80000, res_sat=1.
REQ-031 Bench SHALL cover: res_ready low 10 cycles in RESULT, start pulsed -> res_valid/res_data stable, busy=1, no new mac_clear.
REQ-032 Bench SHALL cover: reset asserted mid-STREAM -> all outputs 0 while reset=1; after release, len=1 (-6,7) -> res_data=-42.
REQ-033 Bench SHALL cover, with MAC_SEQ_REQUANT_EN: shift=2, acc=-42 -> res_q8=-10; acc=1000 -> res_q8=127.
